// File: rtl/vertex_pkg.sv
// Shared constants and width/index helpers for the vertex transform pipeline.
// Latency: none (package only).
// Backpressure: not applicable.
package vertex_pkg;

  localparam int VTX_COMPONENTS = 4;
  localparam int MAT_ELEMS      = 16;

  // Width of one input component or matrix element.
  function automatic int elem_w(input int m, input int n);
    return m + n;
  endfunction

  // Width of one element-by-component product.
  function automatic int prod_w(input int m, input int n);
    return 2 * (m + n);
  endfunction

  // Width of a four-term row sum, with two guard bits for carries.
  function automatic int sum_w(input int m, input int n);
    return 2 * (m + n) + 2;
  endfunction

  // Identity matrix element value: 1.0 on the diagonal, 0 elsewhere.
  function automatic int ident_elem(input int idx, input int n);
    return ((idx / 4) == (idx % 4)) ? (1 << n) : 0;
  endfunction

  // LSB of component k inside a packed vector of w-bit components.
  function automatic int comp_lsb(input int k, input int w);
    return k * w;
  endfunction

  // Column of a row-major matrix element, i.e. the vertex component it scales.
  function automatic int mat_col(input int idx);
    return idx % 4;
  endfunction

endpackage

// File: rtl/vertex_transform_pipe_dot4.sv
// One matrix row: sums four registered products into the registered row sum.
// Latency: 1 cycle (loads on ce).
// Backpressure: holds its sum whenever ce is low.
module vtp_dot4
  import vertex_pkg::*;
#(
  parameter int P = 28,
  parameter int S = 30
) (
  input  logic                clk,
  input  logic                ce,
  input  logic [4*P-1:0]      prods,
  output logic signed [S-1:0] sum
);

  logic signed [S-1:0] row_sum;

  // Sign-extend each product to the sum width and add all four terms.
  always_comb begin
    row_sum = '0;
    for (int k = 0; k < VTX_COMPONENTS; k++) begin
      row_sum = row_sum + S'($signed(prods[k*P +: P]));
    end
  end

  // Row sum register advances with the rest of the pipeline.
  always_ff @(posedge clk) begin
    if (ce) begin
      sum <= row_sum;
    end
  end

endmodule

// File: rtl/vertex_transform_pipe.sv
// 4x4 fixed-point transform of homogeneous vertices with a double-buffered matrix.
// Latency: 3 cycles from input handshake to m_valid; 1 vertex per cycle.
// Backpressure: global stall when m_valid && !m_ready; s_ready follows the stall combinationally.
module vertex_transform_pipe
  import vertex_pkg::*;
#(
  parameter int M        = 11,
  parameter int N        = 3,
  parameter int ROUND    = 0,
  parameter int SATURATE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mat_wr_en,
  input  logic [3:0]            mat_wr_addr,
  input  logic [M+N-1:0]        mat_wr_data,
  input  logic                  mat_commit,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [4*(M+N)-1:0]    s_vertex,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [4*M-1:0]        m_vertex,
  output logic [3:0]            m_ovf,
  output logic [31:0]           vtx_count
);

  localparam int E  = elem_w(M, N);
  localparam int P  = prod_w(M, N);
  localparam int S  = sum_w(M, N);
  localparam int SH = 2 * N;
  // One extra bit so the rounding constant can never wrap the row sum.
  localparam int R  = S + 1;
  localparam int Q  = R - SH;

  localparam logic signed [R-1:0] RND_K   = (ROUND != 0) ? R'(1 << (SH - 1)) : '0;
  localparam logic signed [Q-1:0] MAX_OUT = Q'((1 << (M - 1)) - 1);
  localparam logic signed [Q-1:0] MIN_OUT = Q'(-(1 << (M - 1)));

  logic signed [E-1:0] shadow_mat [MAT_ELEMS];
  logic signed [E-1:0] active_mat [MAT_ELEMS];
  logic signed [P-1:0] s1_prod    [MAT_ELEMS];
  logic [4*P-1:0]      row_prods  [VTX_COMPONENTS];
  logic signed [S-1:0] s2_sum     [VTX_COMPONENTS];
  logic signed [R-1:0] rnd_sum    [VTX_COMPONENTS];
  logic signed [Q-1:0] shf_sum    [VTX_COMPONENTS];
  logic [M-1:0]        res_dat    [VTX_COMPONENTS];
  logic [3:0]          res_ovf;
  logic                ce;
  logic                s1_vld;
  logic                s2_vld;

  assign ce      = !m_valid || m_ready;
  assign s_ready = ce;

  // Matrix buffers: commit copies the shadow as it stood before any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAT_ELEMS; i++) begin
        shadow_mat[i] <= E'(ident_elem(i, N));
        active_mat[i] <= E'(ident_elem(i, N));
      end
    end else begin
      if (mat_commit) begin
        for (int i = 0; i < MAT_ELEMS; i++) begin
          active_mat[i] <= shadow_mat[i];
        end
      end
      if (mat_wr_en) begin
        shadow_mat[mat_wr_addr] <= mat_wr_data;
      end
    end
  end

  // S1: sixteen products of the incoming vertex with the active matrix.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
    end else if (ce) begin
      s1_vld <= s_valid;
      for (int i = 0; i < MAT_ELEMS; i++) begin
        s1_prod[i] <= active_mat[i] * $signed(s_vertex[comp_lsb(mat_col(i), E) +: E]);
      end
    end
  end

  // S2: one adder row per output component.
  for (genvar r = 0; r < VTX_COMPONENTS; r++) begin : g_row
    for (genvar k = 0; k < VTX_COMPONENTS; k++) begin : g_term
      assign row_prods[r][k*P +: P] = s1_prod[4*r + k];
    end
    vtp_dot4 #(.P(P), .S(S)) u_dot4 (
      .clk   (clk),
      .ce    (ce),
      .prods (row_prods[r]),
      .sum   (s2_sum[r])
    );
  end

  // S2 valid tracks the row-sum registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld <= 1'b0;
    end else if (ce) begin
      s2_vld <= s1_vld;
    end
  end

  // Round, drop the 2N fractional bits, then clamp or wrap into M bits.
  always_comb begin
    rnd_sum = '{default: '0};
    shf_sum = '{default: '0};
    res_dat = '{default: '0};
    res_ovf = '0;
    for (int n = 0; n < VTX_COMPONENTS; n++) begin
      rnd_sum[n] = R'(s2_sum[n]) + RND_K;
      shf_sum[n] = Q'(rnd_sum[n] >>> SH);
      res_ovf[n] = (shf_sum[n] > MAX_OUT) || (shf_sum[n] < MIN_OUT);
      if (res_ovf[n] && (SATURATE != 0)) begin
        res_dat[n] = (shf_sum[n] < MIN_OUT) ? MIN_OUT[M-1:0] : MAX_OUT[M-1:0];
      end else begin
        res_dat[n] = shf_sum[n][M-1:0];
      end
    end
  end

  // S3: output register; data only changes when a real vertex moves in.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b0;
      m_vertex <= '0;
      m_ovf    <= '0;
    end else if (ce) begin
      m_valid <= s2_vld;
      if (s2_vld) begin
        for (int n = 0; n < VTX_COMPONENTS; n++) begin
          m_vertex[comp_lsb(n, M) +: M] <= res_dat[n];
        end
        m_ovf <= res_ovf;
      end
    end
  end

  // Delivered-vertex counter, free-running wrap at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      vtx_count <= '0;
    end else if (m_valid && m_ready) begin
      vtx_count <= vtx_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_vertex_transform_pipe.sv
// Self-checking bench: two DUT builds (truncate+saturate, round+wrap) driven identically.
// Latency: checks the 3-cycle handshake-to-output path.
// Backpressure: exercises stalls via m_ready.
module tb_vertex_transform_pipe;

  localparam int M = 11;
  localparam int N = 3;
  localparam int E = M + N;
  localparam int W = 4 * M + 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             mat_wr_en = 1'b0;
  logic [3:0]       mat_wr_addr = '0;
  logic [E-1:0]     mat_wr_data = '0;
  logic             mat_commit = 1'b0;
  logic             s_valid = 1'b0;
  logic [4*E-1:0]   s_vertex = '0;
  logic             m_ready = 1'b0;

  logic             s_ready_a, m_valid_a, s_ready_b, m_valid_b;
  logic [4*M-1:0]   m_vertex_a, m_vertex_b;
  logic [3:0]       m_ovf_a, m_ovf_b;
  logic [31:0]      vtx_count_a, vtx_count_b;

  vertex_transform_pipe #(.M(M), .N(N), .ROUND(0), .SATURATE(1)) dut_a (
    .clk(clk), .rst(rst), .mat_wr_en(mat_wr_en), .mat_wr_addr(mat_wr_addr),
    .mat_wr_data(mat_wr_data), .mat_commit(mat_commit), .s_valid(s_valid),
    .s_ready(s_ready_a), .s_vertex(s_vertex), .m_valid(m_valid_a), .m_ready(m_ready),
    .m_vertex(m_vertex_a), .m_ovf(m_ovf_a), .vtx_count(vtx_count_a)
  );

  vertex_transform_pipe #(.M(M), .N(N), .ROUND(1), .SATURATE(0)) dut_b (
    .clk(clk), .rst(rst), .mat_wr_en(mat_wr_en), .mat_wr_addr(mat_wr_addr),
    .mat_wr_data(mat_wr_data), .mat_commit(mat_commit), .s_valid(s_valid),
    .s_ready(s_ready_b), .s_vertex(s_vertex), .m_valid(m_valid_b), .m_ready(m_ready),
    .m_vertex(m_vertex_b), .m_ovf(m_ovf_b), .vtx_count(vtx_count_b)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: matrices as plain integers, results as queues.
  int am[16];
  int sm[16];
  int cur_v[4];
  logic [W-1:0] exp_a[$], exp_b[$], got_a[$], got_b[$];
  int model_count = 0;
  bit last_acc = 1'b0;

  function automatic logic [W-1:0] model_vtx(input int mat[16], input int v[4],
                                             input bit rnd, input bit sat);
    logic [4*M-1:0] vo;
    logic [3:0] ov;
    longint acc, q;
    vo = '0;
    ov = '0;
    for (int n = 0; n < 4; n++) begin
      acc = 0;
      for (int m = 0; m < 4; m++) acc += longint'(mat[4*n+m]) * longint'(v[m]);
      if (rnd) acc += longint'(1 << (2*N-1));
      q = acc >>> (2*N);
      ov[n] = (q > 1023) || (q < -1024);
      if (ov[n] && sat) q = (q > 0) ? 1023 : -1024;
      vo[n*M +: M] = q[M-1:0];
    end
    return {ov, vo};
  endfunction

  function automatic logic [4*M-1:0] pack_out(input int a, input int b, input int c, input int d);
    logic [4*M-1:0] r;
    int t[4];
    t = '{a, b, c, d};
    for (int k = 0; k < 4; k++) r[k*M +: M] = M'(t[k]);
    return r;
  endfunction

  task automatic set_vertex(input int x, input int y, input int z, input int w);
    cur_v = '{x, y, z, w};
    for (int k = 0; k < 4; k++) s_vertex[k*E +: E] = E'(cur_v[k]);
  endtask

  // Advance one clock; the model observes the handshakes that the coming edge commits.
  task automatic cycle();
    @(negedge clk);
    last_acc = 1'b0;
    if (rst) begin
      exp_a.delete(); exp_b.delete(); got_a.delete(); got_b.delete();
      model_count = 0;
      for (int i = 0; i < 16; i++) begin
        am[i] = (i / 4 == i % 4) ? (1 << N) : 0;
        sm[i] = am[i];
      end
    end else begin
      if (s_valid && s_ready_a) begin
        exp_a.push_back(model_vtx(am, cur_v, 1'b0, 1'b1));
        exp_b.push_back(model_vtx(am, cur_v, 1'b1, 1'b0));
        last_acc = 1'b1;
      end
      if (m_valid_a && m_ready) begin
        got_a.push_back({m_ovf_a, m_vertex_a});
        got_b.push_back({m_ovf_b, m_vertex_b});
        model_count++;
      end
      if (mat_commit) am = sm;
      if (mat_wr_en) sm[mat_wr_addr] = int'($signed(mat_wr_data));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; mat_wr_en = 1'b0; mat_commit = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic write_elem(input int addr, input int data);
    mat_wr_en = 1'b1; mat_wr_addr = 4'(addr); mat_wr_data = E'(data);
    cycle();
    mat_wr_en = 1'b0;
  endtask

  task automatic commit();
    mat_commit = 1'b1;
    cycle();
    mat_commit = 1'b0;
  endtask

  task automatic send_one(input int x, input int y, input int z, input int w);
    set_vertex(x, y, z, w);
    s_valid = 1'b1;
    cycle();
    s_valid = 1'b0;
  endtask

  task automatic drain(input int budget, output bit ok);
    s_valid = 1'b0; mat_wr_en = 1'b0; mat_commit = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < budget && got_a.size() < exp_a.size(); i++) cycle();
    ok = (got_a.size() == exp_a.size()) && (got_b.size() == exp_b.size());
  endtask

  task automatic test_reset();
    rst = 1'b1; m_ready = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    tests_run++; if (m_valid_a !== 1'b0) begin tests_failed++; $display("FAIL reset_m_valid got %0b want 0", m_valid_a); end
    tests_run++; if (m_vertex_a !== '0) begin tests_failed++; $display("FAIL reset_m_vertex got %h want 0", m_vertex_a); end
    tests_run++; if (m_ovf_a !== 4'b0) begin tests_failed++; $display("FAIL reset_m_ovf got %b want 0", m_ovf_a); end
    tests_run++; if (vtx_count_a !== 32'd0 || vtx_count_b !== 32'd0) begin tests_failed++; $display("FAIL reset_vtx_count got %0d/%0d want 0", vtx_count_a, vtx_count_b); end
    tests_run++; if (s_ready_a !== 1'b1) begin tests_failed++; $display("FAIL reset_s_ready got %0b want 1", s_ready_a); end
  endtask

  task automatic test_identity();
    do_reset();
    m_ready = 1'b1;
    send_one(40, -24, 16, 8);
    tests_run++; if (m_valid_a !== 1'b0) begin tests_failed++; $display("FAIL ident_lat1 m_valid got %0b want 0", m_valid_a); end
    cycle();
    tests_run++; if (m_valid_a !== 1'b0) begin tests_failed++; $display("FAIL ident_lat2 m_valid got %0b want 0", m_valid_a); end
    cycle();
    tests_run++; if (m_valid_a !== 1'b1) begin tests_failed++; $display("FAIL ident_lat3 m_valid got %0b want 1", m_valid_a); end
    tests_run++; if (m_vertex_a !== pack_out(5, -3, 2, 1)) begin tests_failed++; $display("FAIL ident_value got %h want %h", m_vertex_a, pack_out(5, -3, 2, 1)); end
    tests_run++; if (m_ovf_a !== 4'b0) begin tests_failed++; $display("FAIL ident_ovf got %b want 0", m_ovf_a); end
    cycle();
    tests_run++; if (vtx_count_a !== 32'd1) begin tests_failed++; $display("FAIL ident_count got %0d want 1", vtx_count_a); end
  endtask

  task automatic test_translation();
    bit ok;
    do_reset();
    write_elem(3, 80); write_elem(7, 160); write_elem(11, 240);
    commit();
    send_one(8, 16, 24, 8);
    drain(20, ok);
    tests_run++; if (!ok || got_a.size() != 1) begin tests_failed++; $display("FAIL xlate_drain got %0d outputs want 1", got_a.size()); end
    else begin
      tests_run++; if (got_a[0] !== {4'b0, pack_out(11, 22, 33, 1)}) begin tests_failed++; $display("FAIL xlate_a got %h want %h", got_a[0], {4'b0, pack_out(11, 22, 33, 1)}); end
      tests_run++; if (got_b[0] !== {4'b0, pack_out(11, 22, 33, 1)}) begin tests_failed++; $display("FAIL xlate_b got %h want %h", got_b[0], {4'b0, pack_out(11, 22, 33, 1)}); end
    end
  endtask

  task automatic test_commit_boundary();
    bit ok;
    logic [W-1:0] want[3];
    do_reset();
    write_elem(3, 80); write_elem(7, 160); write_elem(11, 240);
    m_ready = 1'b1;
    set_vertex(8, 16, 24, 8);
    s_valid = 1'b1;
    cycle();
    mat_commit = 1'b1;
    cycle();
    mat_commit = 1'b0;
    cycle();
    drain(20, ok);
    want[0] = {4'b0, pack_out(1, 2, 3, 1)};
    want[1] = {4'b0, pack_out(1, 2, 3, 1)};
    want[2] = {4'b0, pack_out(11, 22, 33, 1)};
    tests_run++; if (!ok || got_a.size() != 3) begin tests_failed++; $display("FAIL commit_drain got %0d outputs want 3", got_a.size()); end
    else for (int i = 0; i < 3; i++) begin
      tests_run++; if (got_a[i] !== want[i]) begin tests_failed++; $display("FAIL commit_v%0d got %h want %h", i, got_a[i], want[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok, stalled;
    int sent;
    logic [W-1:0] held;
    do_reset();
    sent = 0; stalled = 1'b0; held = '0;
    set_vertex($urandom_range(0, 400) - 200, $urandom_range(0, 400) - 200,
               $urandom_range(0, 400) - 200, 8);
    s_valid = 1'b1;
    for (int t = 0; t < 60 && sent < 6; t++) begin
      m_ready = !(t >= 3 && t < 8);
      #1;
      if (m_valid_a && !m_ready) begin
        tests_run++; if (s_ready_a !== 1'b0 || s_ready_b !== 1'b0) begin tests_failed++; $display("FAIL bp_s_ready t=%0d got %0b want 0", t, s_ready_a); end
        if (stalled) begin
          tests_run++; if ({m_ovf_a, m_vertex_a} !== held) begin tests_failed++; $display("FAIL bp_hold t=%0d got %h want %h", t, {m_ovf_a, m_vertex_a}, held); end
        end
        held = {m_ovf_a, m_vertex_a};
        stalled = 1'b1;
      end else stalled = 1'b0;
      cycle();
      if (last_acc) begin
        sent++;
        set_vertex($urandom_range(0, 400) - 200, $urandom_range(0, 400) - 200,
                   $urandom_range(0, 400) - 200, $urandom_range(0, 16));
      end
    end
    drain(40, ok);
    tests_run++; if (!ok || got_a.size() != 6) begin tests_failed++; $display("FAIL bp_drain got %0d outputs want 6", got_a.size()); end
    else for (int i = 0; i < 6; i++) begin
      tests_run++; if (got_a[i] !== exp_a[i]) begin tests_failed++; $display("FAIL bp_v%0d got %h want %h", i, got_a[i], exp_a[i]); end
    end
    tests_run++; if (vtx_count_a !== 32'd6) begin tests_failed++; $display("FAIL bp_count got %0d want 6", vtx_count_a); end
  endtask

  task automatic test_saturation();
    bit ok;
    do_reset();
    m_ready = 1'b1;
    write_elem(0, 1016);
    commit();
    send_one(800, 0, 0, 8);
    send_one(-800, 0, 0, 8);
    drain(20, ok);
    tests_run++; if (!ok || got_a.size() != 2) begin tests_failed++; $display("FAIL sat_drain got %0d outputs want 2", got_a.size()); end
    else begin
      tests_run++; if (got_a[0][M-1:0] !== 11'd1023 || got_a[0][W-4] !== 1'b1) begin tests_failed++; $display("FAIL sat_pos x=%0d ovf=%b want 1023 ovf 1", got_a[0][M-1:0], got_a[0][W-1:W-4]); end
      tests_run++; if (got_b[0][M-1:0] !== 11'd412 || got_b[0][W-4] !== 1'b1) begin tests_failed++; $display("FAIL wrap_pos x=%0d ovf=%b want 412 ovf 1", got_b[0][M-1:0], got_b[0][W-1:W-4]); end
      tests_run++; if (got_a[1][M-1:0] !== 11'h400 || got_a[1][W-4] !== 1'b1) begin tests_failed++; $display("FAIL sat_neg x=%h ovf=%b want 400 ovf 1", got_a[1][M-1:0], got_a[1][W-1:W-4]); end
      tests_run++; if (got_b[1][M-1:0] !== 11'd1636 || got_b[1][W-4] !== 1'b1) begin tests_failed++; $display("FAIL wrap_neg x=%0d ovf=%b want 1636 ovf 1", got_b[1][M-1:0], got_b[1][W-1:W-4]); end
    end
    write_elem(0, 7);
    commit();
    send_one(5, 0, 0, 8);
    drain(20, ok);
    tests_run++; if (!ok || got_a.size() != 3) begin tests_failed++; $display("FAIL round_drain got %0d outputs want 3", got_a.size()); end
    else begin
      tests_run++; if (got_a[2][M-1:0] !== 11'd0) begin tests_failed++; $display("FAIL trunc x=%0d want 0", got_a[2][M-1:0]); end
      tests_run++; if (got_b[2][M-1:0] !== 11'd1) begin tests_failed++; $display("FAIL round x=%0d want 1", got_b[2][M-1:0]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int big;
    do_reset();
    for (int t = 0; t < 400; t++) begin
      s_valid    = ($urandom_range(0, 9) < 7);
      m_ready    = ($urandom_range(0, 9) < 7);
      mat_wr_en  = ($urandom_range(0, 4) == 0);
      mat_commit = ($urandom_range(0, 9) == 0);
      mat_wr_addr = 4'($urandom_range(0, 15));
      big = $urandom_range(0, 3);
      mat_wr_data = E'((big == 0) ? (int'($urandom_range(0, 4000)) - 2000)
                                  : (int'($urandom_range(0, 40)) - 20));
      set_vertex($urandom_range(0, 4000) - 2000, $urandom_range(0, 4000) - 2000,
                 $urandom_range(0, 4000) - 2000, $urandom_range(0, 64) - 32);
      cycle();
    end
    drain(50, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL rand_drain got %0d outputs want %0d", got_a.size(), exp_a.size()); end
    else begin
      for (int i = 0; i < exp_a.size(); i++) begin
        tests_run++; if (got_a[i] !== exp_a[i]) begin tests_failed++; $display("FAIL rand_a_%0d got %h want %h", i, got_a[i], exp_a[i]); end
        tests_run++; if (got_b[i] !== exp_b[i]) begin tests_failed++; $display("FAIL rand_b_%0d got %h want %h", i, got_b[i], exp_b[i]); end
      end
    end
    tests_run++; if (vtx_count_a !== 32'(model_count)) begin tests_failed++; $display("FAIL rand_count got %0d want %0d", vtx_count_a, model_count); end
  endtask

  task automatic test_reset_midstream();
    bit ok;
    do_reset();
    write_elem(3, 80); write_elem(7, 160); write_elem(11, 240);
    commit();
    m_ready = 1'b0;
    set_vertex(8, 16, 24, 8);
    s_valid = 1'b1;
    cycle(); cycle(); cycle();
    s_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    tests_run++; if (m_valid_a !== 1'b0) begin tests_failed++; $display("FAIL midrst_m_valid got %0b want 0", m_valid_a); end
    tests_run++; if (vtx_count_a !== 32'd0) begin tests_failed++; $display("FAIL midrst_count got %0d want 0", vtx_count_a); end
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    tests_run++; if (got_a.size() != 0) begin tests_failed++; $display("FAIL midrst_stale got %0d outputs want 0", got_a.size()); end
    send_one(8, 16, 24, 8);
    drain(20, ok);
    tests_run++; if (!ok || got_a.size() != 1) begin tests_failed++; $display("FAIL midrst_drain got %0d outputs want 1", got_a.size()); end
    else begin
      tests_run++; if (got_a[0] !== {4'b0, pack_out(1, 2, 3, 1)}) begin tests_failed++; $display("FAIL midrst_identity got %h want %h", got_a[0], {4'b0, pack_out(1, 2, 3, 1)}); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_translation();
    test_commit_boundary();
    test_backpressure();
    test_saturation();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1);
  end

endmodule
